// File: rtl/clk_div_ratio_ctrl.sv
// Run-time ratio controller for the half-integer clock divider.
// Two requesters are arbitrated round-robin. Each request is range-checked.
// An accepted ratio is applied glitch-free: wait for the divider's period end,
// gate the divider, load the new code, wait again, then re-enable.
`timescale 1ns/1ps
module clk_div_ratio_ctrl #(
  parameter int unsigned RATIO_W    = 5,
  parameter int unsigned MIN_X2     = 3,
  parameter int unsigned MAX_X2     = 31,
  parameter int unsigned DEFAULT_X2 = 7,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 62
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         req_valid,
  input  logic [RATIO_W-1:0] req_ratio0,
  input  logic [RATIO_W-1:0] req_ratio1,
  output logic [1:0]         req_ready,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [1:0]         resp_err,
  input  logic               div_period_end,
  output logic               div_en,
  output logic [RATIO_W-1:0] div_ratio_x2,
  output logic               busy
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_END, S_GATE, S_LOAD, S_RESUME, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [RATIO_W-1:0] new_ratio_q, new_ratio_d;
  logic               new_id_q, new_id_d;
  logic [1:0]         cap_err_q, cap_err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               div_en_q, div_en_d;
  logic [RATIO_W-1:0] div_ratio_q, div_ratio_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_id_q, resp_id_d;
  logic [1:0]         resp_err_q, resp_err_d;
  logic               busy_q, busy_d;

  logic [1:0]         grant;
  logic               xfer;
  logic               xfer_id;
  logic [RATIO_W-1:0] xfer_code;
  logic               out_of_range;

  // Round-robin grant: only offered in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant = 2'b00;
    if (state_q == S_IDLE) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready    = grant;
  assign xfer         = |(req_valid & grant);
  assign xfer_id      = grant[1];
  assign xfer_code    = grant[1] ? req_ratio1 : req_ratio0;
  assign out_of_range = (32'(xfer_code) < MIN_X2) || (32'(xfer_code) > MAX_X2);

  // Next-state and registered-output logic for the ratio-change sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    new_ratio_d  = new_ratio_q;
    new_id_d     = new_id_q;
    cap_err_d    = cap_err_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    div_en_d     = div_en_q;
    div_ratio_d  = div_ratio_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          last_grant_d = xfer_id;
          new_id_d     = xfer_id;
          new_ratio_d  = xfer_code;
          if (out_of_range || (xfer_code == div_ratio_q)) begin
            // Rejected or no-op: answer next cycle without touching the divider.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_id_d    = xfer_id;
            resp_err_d   = out_of_range ? ERR_RANGE : ERR_OK;
          end else begin
            state_d   = S_WAIT_END;
            to_cnt_d  = '0;
            cap_err_d = ERR_OK;
          end
        end
      end
      S_WAIT_END: begin
        if (div_period_end || (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
          if (!div_period_end) cap_err_d = ERR_TMO;
          div_en_d = 1'b0;
          // LOAD is the last gated cycle before the new code appears.
          if (GAP_CYCLES > 1) begin
            state_d   = S_GATE;
            gap_cnt_d = GAP_W'(GAP_CYCLES - 2);
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_GATE: begin
        if (gap_cnt_q == '0) state_d = S_LOAD;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      S_LOAD: begin
        div_ratio_d = new_ratio_q;
        state_d     = S_RESUME;
        gap_cnt_d   = GAP_W'(GAP_CYCLES - 1);
      end
      S_RESUME: begin
        if (gap_cnt_q == '0) begin
          div_en_d     = 1'b1;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = new_id_q;
          resp_err_d   = cap_err_q;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight request silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      new_ratio_q  <= RATIO_W'(DEFAULT_X2);
      new_id_q     <= 1'b0;
      cap_err_q    <= ERR_OK;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      div_en_q     <= 1'b1;
      div_ratio_q  <= RATIO_W'(DEFAULT_X2);
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= ERR_OK;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      new_ratio_q  <= new_ratio_d;
      new_id_q     <= new_id_d;
      cap_err_q    <= cap_err_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      div_en_q     <= div_en_d;
      div_ratio_q  <= div_ratio_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign div_en       = div_en_q;
  assign div_ratio_x2 = div_ratio_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_err     = resp_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Bench for clk_div_ratio_ctrl: directed scenarios plus randomized requests,
// checked against a transaction-level reference model of arbitration and timing.
`timescale 1ns/1ps
module tb_clk_div_ratio_ctrl;

  localparam int MIN_X2 = 3;
  localparam int MAX_X2 = 31;
  localparam int GAP    = 2;
  localparam int TMO    = 62;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [4:0] req_ratio0 = 5'd0;
  logic [4:0] req_ratio1 = 5'd0;
  logic [1:0] req_ready;
  logic       resp_valid;
  logic       resp_id;
  logic [1:0] resp_err;
  logic       div_period_end = 1'b0;
  logic       div_en;
  logic [4:0] div_ratio_x2;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: pending requests, round-robin memory, divider code.
  bit         pend [2];
  logic [4:0] code [2];
  bit         m_last  = 1'b1;
  logic [4:0] m_ratio = 5'd7;

  clk_div_ratio_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ratio0(req_ratio0), .req_ratio1(req_ratio1),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .div_period_end(div_period_end),
    .div_en(div_en), .div_ratio_x2(div_ratio_x2), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_req();
    req_valid  = {pend[1], pend[0]};
    req_ratio0 = code[0];
    req_ratio1 = code[1];
  endtask

  function automatic logic [4:0] pick_code();
    if ($urandom_range(0, 7) == 0) return m_ratio;
    return 5'($urandom_range(0, 31));
  endfunction

  // One full transaction, entered just after a negedge with the DUT idle.
  // d = cycles after entering WAIT_END at which period_end pulses; d<0 means never.
  task automatic do_txn(input int d);
    int         g;
    int         p;
    bit         to;
    logic [1:0] exp_g;
    logic [1:0] exp_err;
    logic [4:0] c;
    logic       en_e;
    logic       rv_e;
    logic [4:0] rt_e;

    if (pend[0] && pend[1]) g = m_last ? 0 : 1;
    else                    g = pend[0] ? 0 : 1;
    exp_g = (g == 0) ? 2'b01 : 2'b10;

    drive_req();
    div_period_end = 1'($urandom_range(0, 1));
    #1;
    for (int w = 0; w < 8 && req_ready == 2'b00; w++) begin
      @(negedge clk);
      div_period_end = 1'b0;
      #1;
    end
    chk("grant", 32'(req_ready), 32'(exp_g));
    if (req_ready == 2'b00) return;

    c       = code[g];
    pend[g] = 1'b0;
    m_last  = (g == 1);

    @(negedge clk);
    drive_req();
    div_period_end = 1'b0;
    #1;
    if ((int'(c) < MIN_X2) || (int'(c) > MAX_X2) || (c == m_ratio)) begin
      exp_err = ((int'(c) < MIN_X2) || (int'(c) > MAX_X2)) ? 2'b01 : 2'b00;
      chk("imm_resp",
          32'({resp_valid, resp_id, resp_err, div_en, div_ratio_x2, busy, req_ready}),
          32'({1'b1, g == 1, exp_err, 1'b1, m_ratio, 1'b1, 2'b00}));
    end else begin
      to      = (d < 0) || (d >= TMO);
      p       = to ? TMO : 1 + d;
      exp_err = to ? 2'b10 : 2'b00;
      for (int k = 1; k <= p + 1 + 2*GAP; k++) begin
        if (k > 1) begin
          @(negedge clk);
          drive_req();
        end
        div_period_end = (!to && k == p) ? 1'b1 : ((k > p) ? 1'($urandom_range(0, 1)) : 1'b0);
        #1;
        en_e = !((k >= p + 1) && (k <= p + 2*GAP));
        rt_e = (k >= p + 1 + GAP) ? c : m_ratio;
        rv_e = (k == p + 1 + 2*GAP);
        chk($sformatf("chg k%0d", k),
            32'({resp_valid, div_en, div_ratio_x2, busy, req_ready,
                 (rv_e ? {resp_id, resp_err} : 3'b000)}),
            32'({rv_e, en_e, rt_e, 1'b1, 2'b00,
                 (rv_e ? {g == 1, exp_err} : 3'b000)}));
      end
      m_ratio = c;
    end

    @(negedge clk);
    div_period_end = 1'b0;
    drive_req();
    #1;
    chk("idle", 32'({resp_valid, busy, div_en, div_ratio_x2}), 32'({1'b0, 1'b0, 1'b1, m_ratio}));
  endtask

  logic [5:0] big;
  int         dd;

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    code[0] = 5'd0; code[1] = 5'd0;

    // Reset values.
    @(negedge clk);
    #1;
    chk("reset", 32'({div_en, div_ratio_x2, req_ready, resp_valid, resp_id, resp_err, busy}),
        32'({1'b1, 5'd7, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0}));
    @(negedge clk);
    rstn = 1'b1;

    // Normal change from requester 0.
    pend[0] = 1'b1; code[0] = 5'd9; do_txn(3);

    // Out-of-range, no-op, and truncated-but-legal codes from requester 1.
    pend[1] = 1'b1; code[1] = 5'd2;    do_txn(0);
    pend[1] = 1'b1; code[1] = m_ratio; do_txn(0);
    big = 6'd40;
    pend[1] = 1'b1; code[1] = big[4:0]; do_txn(5);

    // Contention, twice.
    pend[0] = 1'b1; code[0] = 5'd9; pend[1] = 1'b1; code[1] = 5'd11;
    do_txn(2);
    do_txn(4);
    chk("ratio11", 32'(div_ratio_x2), 32'd11);
    pend[0] = 1'b1; code[0] = 5'd9; pend[1] = 1'b1; code[1] = 5'd11;
    do_txn(1);
    do_txn(0);

    // Timeout with no period_end.
    pend[0] = 1'b1; code[0] = 5'd13; do_txn(-1);
    chk("ratio13", 32'(div_ratio_x2), 32'd13);

    // Reset while gated.
    pend[0] = 1'b1; code[0] = 5'd20;
    drive_req();
    div_period_end = 1'b0;
    #1;
    chk("rst_grant", 32'(req_ready), 32'(2'b01));
    pend[0] = 1'b0;
    @(negedge clk);
    drive_req();
    div_period_end = 1'b1;
    @(negedge clk);
    div_period_end = 1'b0;
    #1;
    chk("rst_gate_en", 32'(div_en), 32'd0);
    rstn = 1'b0;
    #1;
    chk("rst_async", 32'({div_en, div_ratio_x2, req_ready, resp_valid, resp_id, resp_err, busy}),
        32'({1'b1, 5'd7, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0}));
    @(negedge clk);
    rstn    = 1'b1;
    m_ratio = 5'd7;
    m_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_quiet", 32'({resp_valid, busy, div_en, div_ratio_x2}), 32'({1'b0, 1'b0, 1'b1, 5'd7}));
    end
    pend[0] = 1'b1; code[0] = 5'd9; do_txn(1);

    // Randomized traffic.
    repeat (40) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          code[i] = pick_code();
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        code[0] = pick_code();
      end
      dd = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
      do_txn(dd);
    end
    while (pend[0] || pend[1]) do_txn(int'($urandom_range(0, 6)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
